sme_input_framer: RTL and testbench
===================================

# sme_input_framer

Upstream feeder for the string-matching engine: accepts a byte stream of ASCII-framed records over a valid/ready handshake, buffers string and pattern records, and replays them to the engine as back-to-back `isstring`/`ispattern` bursts. After each pattern burst it holds off new input until the engine reports a result on its `valid` output. Malformed records are dropped, and a one-cycle error pulse is raised.

## Interface
Parameters:
- STR_MAX, 32, maximum string length in characters; this sets the string buffer depth.
- PAT_MAX, 8, maximum pattern length in characters, including any `^` and `$` characters; this sets the pattern buffer depth.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_ready  output  1  framer can accept a byte; a transfer occurs when `in_valid && in_ready` at a rising edge.
- sme_valid  input  1  engine result strobe; this is the engine's `valid` output.
- chardata  output  8  character to the engine.
- isstring  output  1  `chardata` is a string character.
- ispattern  output  1  `chardata` is a pattern character.
- busy  output  1  high in SEND_S, SEND_P and WAIT_RES.
- err  output  1  one-cycle pulse when a record is discarded.
- err_code  output  2  valid only with `err`. Codes: 1 = bad type byte, 2 = overflow, 3 = empty record or no string loaded.

## Operation
- Record format: a type byte, then characters, then LF (0x0A).
  - Type `S` (0x53) marks a string record.
  - Type `P` (0x50) marks a pattern record.
  - Characters are stored verbatim, except that LF is never stored.
- States:
  - IDLE: accept a type byte. `S` goes to COL_S. `P` goes to COL_P. Any other byte raises err code 1 and goes to DROP. A lone LF in IDLE is ignored.
  - COL_S: store characters at addresses 0..STR_MAX-1.
    - LF with length ≥1: set `str_new` and `str_loaded`, go to IDLE.
    - LF with length 0: err code 3, clear `str_new` and `str_loaded`, go to IDLE.
    - Character STR_MAX+1: err code 2, clear both flags, go to DROP.
  - COL_P: same rules as COL_S with PAT_MAX.
    - LF with length ≥1 and `str_loaded`=1: if `str_new`=1 go to SEND_S, otherwise go to SEND_P.
    - LF with `str_loaded`=0: err code 3, pattern discarded, go to IDLE.
    - Overflow: err code 2, go to DROP. String flags are unchanged.
  - DROP: consume bytes until LF, then go to IDLE. The LF itself is consumed.
  - SEND_S: drive `isstring`=1 with string characters 0..len_s-1, one per cycle. Then go to SEND_P with no gap, and clear `str_new`.
  - SEND_P: drive `ispattern`=1 with pattern characters 0..len_p-1, one per cycle. Then go to WAIT_RES.
  - WAIT_RES: `isstring`=`ispattern`=0 and `chardata`=0. On `sme_valid`=1, go to IDLE.
- A new string record overwrites the pending one. Without a new `S` record, later patterns reuse the engine's resident string, so only SEND_P is run.
- `sme_valid` outside WAIT_RES is ignored.
- Length counters are 6 bits for the string and 4 bits for the pattern, so the overflow character is detectable without wrap-around.

## Timing
- Reset values: `in_ready`=0, `isstring`=0, `ispattern`=0, `chardata`=0, `busy`=0, `err`=0, `err_code`=0.
  - State resets to IDLE; `str_new`, `str_loaded` and both lengths reset to 0.
  - `in_ready` rises at the first clk edge after reset deasserts.
- All outputs are registered.
- `in_ready`=1 in IDLE, COL_S, COL_P and DROP. It goes 0 in the cycle after the terminating LF of a sendable pattern is accepted.
- If the pattern LF is accepted at edge t:
  - The first character is driven from edge t+1.
  - The burst is len_s+len_p cycles when a new string is pending, otherwise len_p cycles.
  - `isstring` and `ispattern` are never high together.
  - There are no idle cycles inside a burst.
- `err` is high for the cycle after the offending byte is accepted.
- When `sme_valid` is sampled high in WAIT_RES at edge r, `in_ready`=1 and `busy`=0 from edge r.
- Reset asserted mid-burst: outputs drop to 0 immediately (asynchronously), and all records are discarded.

## Test plan
- Send `S`,"ABCD",LF,`P`,"BC",LF. Required:
  - `isstring` high for 4 cycles carrying A,B,C,D.
  - Then `ispattern` high for 2 cycles carrying B,C, back-to-back.
  - `in_ready`=0 until `sme_valid` is pulsed, and `in_ready`=1 from that edge.
- Follow with `P`,"^A",LF. Required: only a 2-cycle `ispattern` burst (^,A) and no `isstring`.
- Send `P`,"X",LF straight after reset. Required: `err`=1 with `err_code`=3, no burst, `in_ready` stays 1.
- Send `S` with 33 characters, then LF. Required: `err_code`=2 on character 33, the rest dropped through LF. A following `P` record gets `err_code`=3.
- Send type byte `Q`, then "AB",LF. Required: `err_code`=1, then return to IDLE. The next valid `S`/`P` pair is sent correctly.
- Assert reset during SEND_S. Required: `isstring` goes 0 asynchronously, `in_ready`=0 while reset is low, and a later `P` record reports `err_code`=3.

Source files
------------

// File: rtl/sme_input_framer_if.sv
// sme_input_framer_if
// Bundles the upstream byte handshake, the engine result strobe and the
// engine-facing character bus of the input framer.
//   in_valid/in_data/in_ready : upstream byte stream (valid/ready)
//   sme_valid                 : engine result strobe
//   chardata/isstring/ispattern : character burst to the engine
//   busy, err, err_code       : framer status
// master = upstream/engine side, slave = framer.
interface sme_input_framer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       sme_valid;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       busy;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output in_valid, in_data, sme_valid,
        input  in_ready, chardata, isstring, ispattern, busy, err, err_code
    );

    modport slave (
        input  in_valid, in_data, sme_valid,
        output in_ready, chardata, isstring, ispattern, busy, err, err_code
    );
endinterface

// File: rtl/sme_input_framer.sv
// sme_input_framer
// Parses ASCII records (type byte, characters, LF) from a byte stream,
// buffers the latest string and pattern, and replays them to the matching
// engine as back-to-back isstring / ispattern bursts. After a pattern burst
// it waits for the engine's result strobe before accepting more input.
// Malformed records are dropped with a one-cycle err pulse.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : sme_input_framer_if.slave (handshake, engine bus, status)
module sme_input_framer #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8
) (
    input logic               clk,
    input logic               reset,
    sme_input_framer_if.slave bus
);
    localparam int         SAW     = $clog2(STR_MAX);
    localparam int         PAW     = $clog2(PAT_MAX);
    localparam logic [5:0] STR_LIM = 6'(STR_MAX);
    localparam logic [3:0] PAT_LIM = 4'(PAT_MAX);
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_S    = 8'h53;
    localparam logic [7:0] CH_P    = 8'h50;

    typedef enum logic [2:0] {
        IDLE, COL_S, COL_P, DROP, SEND_S, SEND_P, WAIT_RES
    } state_t;

    state_t     state, state_d;
    logic [7:0] str_buf [STR_MAX];
    logic [7:0] pat_buf [PAT_MAX];
    logic [5:0] len_s, len_s_d;
    logic [3:0] len_p, len_p_d;
    logic [5:0] idx, idx_d;           // replay pointer shared by both bursts
    logic       str_new, str_new_d;   // string not yet sent to the engine
    logic       str_loaded, str_loaded_d;
    logic       s_we, p_we;
    logic       in_ready_d, busy_d, isstring_d, ispattern_d, err_d;
    logic [7:0] chardata_d;
    logic [1:0] err_code_d;
    logic       acc, is_lf;

    assign acc   = bus.in_valid && bus.in_ready;
    assign is_lf = (bus.in_data == CH_LF);

    always_comb begin
        state_d      = state;
        len_s_d      = len_s;
        len_p_d      = len_p;
        idx_d        = idx;
        str_new_d    = str_new;
        str_loaded_d = str_loaded;
        s_we         = 1'b0;
        p_we         = 1'b0;
        err_d        = 1'b0;
        err_code_d   = 2'd0;
        chardata_d   = 8'd0;
        isstring_d   = 1'b0;
        ispattern_d  = 1'b0;

        unique case (state)
            IDLE: if (acc) begin
                if (bus.in_data == CH_S) begin
                    state_d = COL_S;
                    len_s_d = 6'd0;
                end else if (bus.in_data == CH_P) begin
                    state_d = COL_P;
                    len_p_d = 4'd0;
                end else if (!is_lf) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    state_d    = DROP;
                end
            end
            COL_S: if (acc) begin
                if (is_lf) begin
                    state_d = IDLE;
                    if (len_s == 6'd0) begin
                        err_d        = 1'b1;
                        err_code_d   = 2'd3;
                        str_new_d    = 1'b0;
                        str_loaded_d = 1'b0;
                    end else begin
                        str_new_d    = 1'b1;
                        str_loaded_d = 1'b1;
                    end
                end else if (len_s == STR_LIM) begin
                    // buffer already full: this is the overflow character
                    err_d        = 1'b1;
                    err_code_d   = 2'd2;
                    str_new_d    = 1'b0;
                    str_loaded_d = 1'b0;
                    state_d      = DROP;
                end else begin
                    s_we    = 1'b1;
                    len_s_d = len_s + 6'd1;
                end
            end
            COL_P: if (acc) begin
                if (is_lf) begin
                    if (len_p == 4'd0 || !str_loaded) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd3;
                        state_d    = IDLE;
                    end else begin
                        idx_d   = 6'd0;
                        state_d = str_new ? SEND_S : SEND_P;
                    end
                end else if (len_p == PAT_LIM) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = DROP;
                end else begin
                    p_we    = 1'b1;
                    len_p_d = len_p + 4'd1;
                end
            end
            DROP: if (acc && is_lf) state_d = IDLE;
            SEND_S: begin
                chardata_d = str_buf[idx[SAW-1:0]];
                isstring_d = 1'b1;
                if (idx == len_s - 6'd1) begin
                    idx_d     = 6'd0;
                    str_new_d = 1'b0;
                    state_d   = SEND_P;
                end else begin
                    idx_d = idx + 6'd1;
                end
            end
            SEND_P: begin
                chardata_d  = pat_buf[idx[PAW-1:0]];
                ispattern_d = 1'b1;
                if (idx == {2'b00, len_p} - 6'd1) state_d = WAIT_RES;
                else                               idx_d   = idx + 6'd1;
            end
            WAIT_RES: if (bus.sme_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // status outputs follow the state being entered so they are registered
        in_ready_d = (state_d == IDLE) || (state_d == COL_S) ||
                     (state_d == COL_P) || (state_d == DROP);
        busy_d     = !in_ready_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            len_s         <= 6'd0;
            len_p         <= 4'd0;
            idx           <= 6'd0;
            str_new       <= 1'b0;
            str_loaded    <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.chardata  <= 8'd0;
            bus.isstring  <= 1'b0;
            bus.ispattern <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
            bus.err_code  <= 2'd0;
        end else begin
            state         <= state_d;
            len_s         <= len_s_d;
            len_p         <= len_p_d;
            idx           <= idx_d;
            str_new       <= str_new_d;
            str_loaded    <= str_loaded_d;
            bus.in_ready  <= in_ready_d;
            bus.chardata  <= chardata_d;
            bus.isstring  <= isstring_d;
            bus.ispattern <= ispattern_d;
            bus.busy      <= busy_d;
            bus.err       <= err_d;
            bus.err_code  <= err_code_d;
        end
    end

    // character storage needs no reset: lengths and flags gate every read
    always_ff @(posedge clk) begin
        if (s_we) str_buf[len_s[SAW-1:0]] <= bus.in_data;
        if (p_we) pat_buf[len_p[PAW-1:0]] <= bus.in_data;
    end
endmodule

// File: tb/tb_sme_input_framer.sv
module tb_sme_input_framer;
    localparam int         STR_MAX = 32;
    localparam int         PAT_MAX = 8;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_S    = 8'h53;
    localparam logic [7:0] CH_P    = 8'h50;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sme_input_framer_if bus_if ();

    sme_input_framer #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        logic       s;
    } exp_t;

    exp_t       exp_q [$];
    int         err_q [$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic       in_burst = 1'b0;
    bit         gaps_on = 1'b0;

    // reference model: record-level view of what the engine should receive
    logic [7:0] rec   [$];
    logic [7:0] m_str [$];
    bit         m_new = 1'b0;
    bit         m_loaded = 1'b0;

    task automatic check(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic set_rec(input string s);
        rec.delete();
        for (int i = 0; i < s.len(); i++) rec.push_back(s[i]);
    endtask

    task automatic model_rec(input logic [7:0] t, output bit sendable);
        sendable = 1'b0;
        if (t == CH_S) begin
            if (rec.size() == 0) begin
                err_q.push_back(3); m_new = 1'b0; m_loaded = 1'b0;
            end else if (rec.size() > STR_MAX) begin
                err_q.push_back(2); m_new = 1'b0; m_loaded = 1'b0;
            end else begin
                m_str = rec; m_new = 1'b1; m_loaded = 1'b1;
            end
        end else if (t == CH_P) begin
            if (rec.size() > PAT_MAX) err_q.push_back(2);
            else if (rec.size() == 0 || !m_loaded) err_q.push_back(3);
            else begin
                if (m_new) foreach (m_str[i]) exp_q.push_back('{m_str[i], 1'b1});
                foreach (rec[i]) exp_q.push_back('{rec[i], 1'b0});
                m_new    = 1'b0;
                sendable = 1'b1;
            end
        end else begin
            err_q.push_back(1);
        end
    endtask

    // returns #1 after the edge at which the byte was accepted
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (gaps_on) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = b;
        forever begin
            @(negedge clk);
            if (bus_if.in_ready) break;
            n++;
            if (n > 200) begin
                check("in_ready_timeout", int'(bus_if.in_ready), 1);
                bus_if.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] t);
        send_byte(t);
        foreach (rec[i]) send_byte(rec[i]);
        send_byte(CH_LF);
    endtask

    task automatic finish_burst();
        int n;
        check("ready_low_after_lf", int'(bus_if.in_ready), 0);
        check("no_char_at_lf_edge", int'(bus_if.isstring | bus_if.ispattern), 0);
        @(posedge clk); #1;
        check("first_char_next_edge", int'(bus_if.isstring | bus_if.ispattern), 1);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #2; n++; end
        check("burst_drained", exp_q.size(), 0);
        check("ready_low_wait", int'(bus_if.in_ready), 0);
        check("busy_wait", int'(bus_if.busy), 1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #2;
        bus_if.sme_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.sme_valid = 1'b0;
        check("ready_after_valid", int'(bus_if.in_ready), 1);
        check("busy_after_valid", int'(bus_if.busy), 0);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
        check("err_drained", err_q.size(), 0);
        check("ready_idle", int'(bus_if.in_ready), 1);
    endtask

    task automatic send_rec(input logic [7:0] t);
        bit s;
        model_rec(t, s);
        send_bytes(t);
        if (s) finish_burst();
        else   settle();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            in_burst = 1'b0;
        end else begin
            if (bus_if.isstring && bus_if.ispattern) check("both_high", 1, int'(bus_if.isstring & ~bus_if.ispattern));
            if (bus_if.isstring || bus_if.ispattern) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_char", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("char_value", int'(bus_if.chardata), int'(e.ch));
                    check("char_kind", int'(bus_if.isstring), int'(e.s));
                    in_burst = (exp_q.size() != 0);
                end
            end else if (in_burst) begin
                check("burst_gap", int'(bus_if.isstring | bus_if.ispattern), 1);
                in_burst = 1'b0;
            end
            if (bus_if.err) begin
                if (err_q.size() == 0) check("unexpected_err", int'(bus_if.err_code), 0);
                else check("err_code", int'(bus_if.err_code), err_q.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         s;
        int         n, r, len;
        logic [7:0] t;

        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 8'd0;
        bus_if.sme_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(bus_if.in_ready), 0);
        check("rst_isstring", int'(bus_if.isstring), 0);
        check("rst_ispattern", int'(bus_if.ispattern), 0);
        check("rst_chardata", int'(bus_if.chardata), 0);
        check("rst_busy", int'(bus_if.busy), 0);
        check("rst_err", int'(bus_if.err), 0);
        check("rst_err_code", int'(bus_if.err_code), 0);
        @(negedge clk) reset = 1'b1;
        #1 check("ready_before_edge", int'(bus_if.in_ready), 0);
        @(posedge clk); #1;
        check("ready_first_edge", int'(bus_if.in_ready), 1);

        // pattern with no string loaded
        set_rec("X");    send_rec(CH_P);
        // new string plus pattern, then pattern reusing resident string
        set_rec("ABCD"); send_rec(CH_S);
        set_rec("BC");   send_rec(CH_P);
        set_rec("^A");   send_rec(CH_P);
        // string overflow on character 33, then pattern has no string
        rec.delete();
        for (int i = 0; i < STR_MAX + 1; i++) rec.push_back(8'(65 + i % 26));
        send_rec(CH_S);
        set_rec("Z");    send_rec(CH_P);
        // bad type byte
        set_rec("AB");
        model_rec(8'h51, s);
        send_byte(8'h51);
        check("bad_type_err", int'(bus_if.err), 1);
        check("bad_type_code", int'(bus_if.err_code), 1);
        @(posedge clk); #1;
        check("err_one_cycle", int'(bus_if.err), 0);
        foreach (rec[i]) send_byte(rec[i]);
        send_byte(CH_LF);
        settle();
        set_rec("HELLO"); send_rec(CH_S);
        set_rec("LL");    send_rec(CH_P);

        // reset during SEND_S
        set_rec("ABCDEFGH"); model_rec(CH_S, s); send_bytes(CH_S);
        set_rec("AB");       model_rec(CH_P, s); send_bytes(CH_P);
        n = 0;
        while (!bus_if.isstring && n < 50) begin @(negedge clk); n++; end
        check("burst_started", int'(bus_if.isstring), 1);
        @(posedge clk); #2;
        reset = 1'b0;
        exp_q.delete(); err_q.delete();
        m_new = 1'b0; m_loaded = 1'b0;
        #1;
        check("async_rst_isstring", int'(bus_if.isstring), 0);
        check("async_rst_ready", int'(bus_if.in_ready), 0);
        check("async_rst_busy", int'(bus_if.busy), 0);
        repeat (2) @(negedge clk);
        check("rst_hold_ready", int'(bus_if.in_ready), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        set_rec("X"); send_rec(CH_P);

        // randomized records
        gaps_on = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus_if.sme_valid = 1'b1;
                @(posedge clk); #1;
                bus_if.sme_valid = 1'b0;
                check("stray_valid_ready", int'(bus_if.in_ready), 1);
            end
            r = $urandom_range(0, 19);
            if (r < 8) begin
                t = CH_S;
                r = $urandom_range(0, 19);
                len = (r == 0) ? 0 : (r < 3) ? $urandom_range(STR_MAX + 1, STR_MAX + 4)
                                             : $urandom_range(1, STR_MAX);
            end else if (r < 17) begin
                t = CH_P;
                r = $urandom_range(0, 9);
                len = (r == 0) ? $urandom_range(PAT_MAX + 1, PAT_MAX + 3)
                               : $urandom_range(1, PAT_MAX);
            end else begin
                do t = 8'($urandom_range(65, 90)); while (t == CH_S || t == CH_P);
                len = $urandom_range(0, 5);
            end
            rec.delete();
            for (int i = 0; i < len; i++) rec.push_back(8'($urandom_range(32, 126)));
            send_rec(t);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
